// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for the sprite scheduler
// Purpose: screen geometry, sprite code enumeration and the actor descriptor
// shared by sprite_sched and actor_hit. No ports.
package sprite_pkg;

  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int TILE_W   = 8;
  localparam int MAP_COLS = H_RES / TILE_W;
  localparam int MAP_ROWS = V_RES / TILE_W;

  localparam logic [2:0] ACTOR_NONE = 3'd7;

  typedef enum logic [3:0] {
    GHOST0     = 4'b0000,
    GHOST1     = 4'b0001,
    GHOST2     = 4'b0010,
    GHOST3     = 4'b0011,
    GHOST4     = 4'b0100,
    GHOST5     = 4'b0101,
    GHOST6     = 4'b0110,
    GHOST7     = 4'b0111,
    PACMAN     = 4'b1001,
    BLANK_CODE = 4'hA
  } sprite_code_t;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] code;
  } actor_t;

endpackage

// File: rtl/actor_hit.sv
// rtl/actor_hit.sv - combinational pixel-vs-actor overlap test
// Purpose: decides whether the pixel (px_x, px_y) lies inside the 8x8 box of
// one actor and gives the offset inside that box.
// Ports:
//   px_x, px_y   : pixel being tested
//   actor        : actor descriptor (enable, top-left, code)
//   hit          : pixel is inside an enabled actor
//   off_x, off_y : column/row inside the actor sprite (valid when hit)
module actor_hit
  import sprite_pkg::*;
(
  input  logic [9:0] px_x,
  input  logic [9:0] px_y,
  input  actor_t     actor,
  output logic       hit,
  output logic [2:0] off_x,
  output logic [2:0] off_y
);

  // 11-bit signed so a pixel left of / above the actor goes negative instead
  // of wrapping into the 0..7 window (actors near the right/bottom edge clip).
  logic signed [10:0] dx;
  logic signed [10:0] dy;

  assign dx = $signed({1'b0, px_x}) - $signed({1'b0, actor.x});
  assign dy = $signed({1'b0, px_y}) - $signed({1'b0, actor.y});

  // 0 <= d < 8  <=>  sign bit clear and bits [9:3] all zero
  assign hit = actor.en
             & ~dx[10] & (dx[9:3] == 7'd0)
             & ~dy[10] & (dy[9:3] == 7'd0);

  assign off_x = dx[2:0];
  assign off_y = dy[2:0];

endmodule

// File: rtl/sprite_sched.sv
// rtl/sprite_sched.sv - per-pixel background/actor scheduler
// Purpose: fetches the background tile for each pixel, arbitrates it against
// up to N_ACTORS 8x8 actors and registers the selected sprite triple two
// clocks after the pixel coordinates, plus a sticky Pacman/ghost collision.
// Ports:
//   clk, rst_n                 : pixel clock, async active-low reset
//   px_x, px_y, px_de          : pixel counters and active-area flag
//   frame_start                : pulse before the first active pixel
//   tile_rd_en, tile_addr      : tile RAM read request (row*MAP_COLS+col)
//   tile_data                  : tile code, one cycle after tile_rd_en
//   actor_en/x/y/code          : live actor descriptors (latched per frame)
//   sprite_x, sprite_y         : offset inside the selected 8x8 sprite
//   sprite_code                : selected sprite code
//   de_out                     : active flag aligned with the outputs
//   actor_sel                  : winning actor index, 7 for background
//   collision                  : Pacman overlapped a ghost this frame
module sprite_sched
  import sprite_pkg::*;
#(
  parameter int N_ACTORS = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               px_x,
  input  logic [9:0]               px_y,
  input  logic                     px_de,
  input  logic                     frame_start,
  output logic                     tile_rd_en,
  output logic [12:0]              tile_addr,
  input  logic [3:0]               tile_data,
  input  logic [N_ACTORS-1:0]      actor_en,
  input  logic [N_ACTORS-1:0][9:0] actor_x,
  input  logic [N_ACTORS-1:0][9:0] actor_y,
  input  logic [N_ACTORS-1:0][3:0] actor_code,
  output logic [2:0]               sprite_x,
  output logic [2:0]               sprite_y,
  output logic [3:0]               sprite_code,
  output logic                     de_out,
  output logic [2:0]               actor_sel,
  output logic                     collision
);

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   run_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_FRAME;
    else        state_q <= state_d;
  end

  // run_now is also high on the frame_start cycle out of WAIT_FRAME so a
  // pixel coinciding with frame_start is fetched with the fresh shadows.
  always_comb begin
    state_d = state_q;
    run_now = 1'b0;
    case (state_q)
      WAIT_FRAME: begin
        if (frame_start) begin
          state_d = RUN;
          run_now = 1'b1;
        end
      end
      RUN:     run_now = 1'b1;
      default: state_d = WAIT_FRAME;
    endcase
  end

  // ---------------- stage 0: tile fetch ----------------
  logic        in_range;
  logic        s0_valid;
  logic [12:0] tile_row;
  logic [12:0] tile_col;

  assign in_range = (px_x < 10'(H_RES)) && (px_y < 10'(V_RES));
  assign s0_valid = run_now & px_de & in_range;
  assign tile_row = 13'(px_y[9:3]);
  assign tile_col = 13'(px_x[9:3]);

  assign tile_rd_en = s0_valid;
  assign tile_addr  = s0_valid ? (tile_row * 13'(MAP_COLS) + tile_col) : 13'd0;

  // Shadows change only on frame_start so actors never tear mid-frame.
  actor_t shadow_q [N_ACTORS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ACTORS; i++) shadow_q[i] <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < N_ACTORS; i++)
        shadow_q[i] <= '{en: actor_en[i], x: actor_x[i], y: actor_y[i], code: actor_code[i]};
    end
  end

  logic       s1_valid;
  logic [9:0] s1_x;
  logic [9:0] s1_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= s0_valid;
      s1_x     <= px_x;
      s1_y     <= px_y;
    end
  end

  // ---------------- stage 1: actor compare ----------------
  logic [N_ACTORS-1:0]      hit;
  logic [N_ACTORS-1:0][2:0] off_x;
  logic [N_ACTORS-1:0][2:0] off_y;

  for (genvar g = 0; g < N_ACTORS; g++) begin : g_hit
    actor_hit u_actor_hit (
      .px_x  (s1_x),
      .px_y  (s1_y),
      .actor (shadow_q[g]),
      .hit   (hit[g]),
      .off_x (off_x[g]),
      .off_y (off_y[g])
    );
  end

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] win_ox;
  logic [2:0] win_oy;
  logic [3:0] win_code;
  logic       pac_ghost;

  // Scan from the top down so the lowest-index hitting actor wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ACTOR_NONE;
    win_ox    = 3'd0;
    win_oy    = 3'd0;
    win_code  = 4'd0;
    for (int i = N_ACTORS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
        win_ox    = off_x[i];
        win_oy    = off_y[i];
        win_code  = shadow_q[i].code;
      end
    end
  end

  assign pac_ghost = s1_valid & hit[0] & (|hit[N_ACTORS-1:1]);

  // ---------------- stage 2: output register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sprite_x    <= 3'd0;
      sprite_y    <= 3'd0;
      sprite_code <= BLANK_CODE;
      actor_sel   <= ACTOR_NONE;
      de_out      <= 1'b0;
      collision   <= 1'b0;
    end else begin
      de_out <= s1_valid;
      if (!s1_valid) begin
        sprite_x    <= 3'd0;
        sprite_y    <= 3'd0;
        sprite_code <= BLANK_CODE;
        actor_sel   <= ACTOR_NONE;
      end else if (win_found) begin
        sprite_x    <= win_ox;
        sprite_y    <= win_oy;
        sprite_code <= win_code;
        actor_sel   <= win_idx;
      end else begin
        sprite_x    <= s1_x[2:0];
        sprite_y    <= s1_y[2:0];
        sprite_code <= tile_data;
        actor_sel   <= ACTOR_NONE;
      end
      // Clear has priority so a new frame always starts collision-free.
      if (frame_start)    collision <= 1'b0;
      else if (pac_ghost) collision <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_sched.sv
// tb/tb_sprite_sched.sv - directed self-checking bench for sprite_sched
module tb_sprite_sched;

  localparam int N = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [9:0]        px_x, px_y;
  logic              px_de, frame_start;
  logic              tile_rd_en;
  logic [12:0]       tile_addr;
  logic [3:0]        tile_data;
  logic [N-1:0]      actor_en;
  logic [N-1:0][9:0] actor_x, actor_y;
  logic [N-1:0][3:0] actor_code;
  logic [2:0]        sprite_x, sprite_y;
  logic [3:0]        sprite_code;
  logic              de_out;
  logic [2:0]        actor_sel;
  logic              collision;
  logic [3:0]        tile_fill;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Tile RAM model: one-cycle read latency, returns tile_fill.
  always @(posedge clk) tile_data <= tile_rd_en ? tile_fill : 4'hF;

  sprite_sched #(.N_ACTORS(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .px_x        (px_x),
    .px_y        (px_y),
    .px_de       (px_de),
    .frame_start (frame_start),
    .tile_rd_en  (tile_rd_en),
    .tile_addr   (tile_addr),
    .tile_data   (tile_data),
    .actor_en    (actor_en),
    .actor_x     (actor_x),
    .actor_y     (actor_y),
    .actor_code  (actor_code),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .sprite_code (sprite_code),
    .de_out      (de_out),
    .actor_sel   (actor_sel),
    .collision   (collision)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic de);
    px_x  = x;
    px_y  = y;
    px_de = de;
  endtask

  task automatic set_actor(input int i, input logic en, input logic [9:0] x,
                           input logic [9:0] y, input logic [3:0] code);
    actor_en[i]   = en;
    actor_x[i]    = x;
    actor_y[i]    = y;
    actor_code[i] = code;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    px_de       = 1'b0;
    tick();
    frame_start = 1'b0;
  endtask

  // Present one pixel, then an idle cycle; outputs for it are then visible.
  task automatic show_px(input logic [9:0] x, input logic [9:0] y);
    drive(x, y, 1'b1);
    tick();
    px_de = 1'b0;
    tick();
  endtask

  task automatic expect_out(input string tag, input logic [3:0] code, input logic [2:0] sx,
                            input logic [2:0] sy, input logic [2:0] sel, input logic de,
                            input logic coll);
    check({tag, ".code"}, 32'(sprite_code), 32'(code));
    check({tag, ".sx"},   32'(sprite_x),    32'(sx));
    check({tag, ".sy"},   32'(sprite_y),    32'(sy));
    check({tag, ".sel"},  32'(actor_sel),   32'(sel));
    check({tag, ".de"},   32'(de_out),      32'(de));
    check({tag, ".coll"}, 32'(collision),   32'(coll));
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    tile_fill   = 4'd0;
    actor_en    = '0;
    actor_x     = '0;
    actor_y     = '0;
    actor_code  = '0;
    drive(10'd0, 10'd0, 1'b0);
    repeat (3) tick();
    expect_out("reset", 4'hA, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0);
    check("reset.rd_en", 32'(tile_rd_en), 32'd0);
    rst_n = 1'b1;
    tick();

    // WAIT_FRAME: active pixels do not start reads
    drive(10'd17, 10'd9, 1'b1);
    #1;
    check("wait.rd_en", 32'(tile_rd_en), 32'd0);
    tick();
    px_de = 1'b0;
    tick();
    expect_out("wait", 4'hA, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0);

    // 1: background tile
    pulse_fs();
    tile_fill = 4'd3;
    drive(10'd17, 10'd9, 1'b1);
    #1;
    check("t1.rd_en", 32'(tile_rd_en), 32'd1);
    check("t1.addr",  32'(tile_addr),  32'd82);
    tick();
    px_de = 1'b0;
    tick();
    expect_out("t1", 4'd3, 3'd1, 3'd1, 3'd7, 1'b1, 1'b0);

    // 2: Pacman over a ghost, lowest index wins, sticky collision
    set_actor(0, 1'b1, 10'd16, 10'd8, 4'd9);
    set_actor(2, 1'b1, 10'd18, 10'd8, 4'd2);
    pulse_fs();
    show_px(10'd19, 10'd10);
    expect_out("t2.hit", 4'd9, 3'd3, 3'd2, 3'd0, 1'b1, 1'b1);
    show_px(10'd100, 10'd100);
    expect_out("t2.held", 4'd3, 3'd4, 3'd4, 3'd7, 1'b1, 1'b1);
    pulse_fs();
    check("t2.clear", 32'(collision), 32'd0);
    show_px(10'd24, 10'd9);
    expect_out("t2.ghost", 4'd2, 3'd6, 3'd1, 3'd2, 1'b1, 1'b0);

    // 3: clipping at the bottom-right corner, no wrap to (0,0), disabled actors
    set_actor(0, 1'b0, 10'd16, 10'd8, 4'd9);
    set_actor(2, 1'b0, 10'd18, 10'd8, 4'd2);
    set_actor(1, 1'b1, 10'd636, 10'd476, 4'd5);
    pulse_fs();
    tile_fill = 4'd7;
    drive(10'd639, 10'd479, 1'b1);
    #1;
    check("t3.addr", 32'(tile_addr), 32'd4799);
    tick();
    px_de = 1'b0;
    tick();
    expect_out("t3.corner", 4'd5, 3'd3, 3'd3, 3'd1, 1'b1, 1'b0);
    show_px(10'd0, 10'd0);
    expect_out("t3.nowrap", 4'd7, 3'd0, 3'd0, 3'd7, 1'b1, 1'b0);
    show_px(10'd19, 10'd10);
    expect_out("t3.dis", 4'd7, 3'd3, 3'd2, 3'd7, 1'b1, 1'b0);

    // 4: live actor change ignored until frame_start; same-cycle fs uses new shadow
    actor_x[1] = 10'd0;
    show_px(10'd2, 10'd477);
    expect_out("t4.old", 4'd7, 3'd2, 3'd5, 3'd7, 1'b1, 1'b0);
    frame_start = 1'b1;
    drive(10'd2, 10'd477, 1'b1);
    tick();
    frame_start = 1'b0;
    px_de = 1'b0;
    tick();
    expect_out("t4.new", 4'd5, 3'd2, 3'd1, 3'd1, 1'b1, 1'b0);

    // 5: inactive and out-of-range pixels
    drive(10'd5, 10'd5, 1'b0);
    #1;
    check("t5.de0.rd", 32'(tile_rd_en), 32'd0);
    tick();
    tick();
    expect_out("t5.de0", 4'hA, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0);
    drive(10'd700, 10'd10, 1'b1);
    #1;
    check("t5.x700.rd",   32'(tile_rd_en), 32'd0);
    check("t5.x700.addr", 32'(tile_addr),  32'd0);
    tick();
    px_de = 1'b0;
    tick();
    expect_out("t5.x700", 4'hA, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0);
    drive(10'd10, 10'd480, 1'b1);
    #1;
    check("t5.y480.rd", 32'(tile_rd_en), 32'd0);
    tick();
    px_de = 1'b0;
    tick();
    expect_out("t5.y480", 4'hA, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0);

    // 6: async reset with a full pipeline of hits
    set_actor(0, 1'b1, 10'd100, 10'd100, 4'd9);
    set_actor(1, 1'b1, 10'd100, 10'd100, 4'd3);
    pulse_fs();
    drive(10'd101, 10'd101, 1'b1);
    tick();
    drive(10'd102, 10'd101, 1'b1);
    tick();
    expect_out("t6.pre", 4'd9, 3'd1, 3'd1, 3'd0, 1'b1, 1'b1);
    rst_n = 1'b0;
    #2;
    expect_out("t6.rst", 4'hA, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0);
    check("t6.rst.rd", 32'(tile_rd_en), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t6.idle.rd", 32'(tile_rd_en), 32'd0);
    expect_out("t6.idle", 4'hA, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0);
    frame_start = 1'b1;
    drive(10'd101, 10'd101, 1'b1);
    #1;
    check("t6.fs.rd",   32'(tile_rd_en), 32'd1);
    check("t6.fs.addr", 32'(tile_addr),  32'd972);
    tick();
    frame_start = 1'b0;
    px_de = 1'b0;
    tick();
    expect_out("t6.resume", 4'd9, 3'd1, 3'd1, 3'd0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
